mmio_wr_buffer: RTL
===================

# mmio_wr_buffer

Upstream capture stage for host MMIO writes. It sits between the CCI-P Rx c0 MMIO decode and the user register logic. Writes to the configured user address are pushed into a circular FIFO, so bursts of host writes are not lost while the consumer is busy. The consumer drains entries with a valid/ready handshake; occupancy and a sticky overflow flag are exported for status readback.

## Interface
- DEPTH, 8: FIFO entries; power of two, at least 2.
- ADDR_W, 16: MMIO address width (CCI-P 32-bit-word address).
- DATA_W, 64: write data width.
- ACCEPT_ADDR, 16'h0020: the only MMIO address that is captured.
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- wr_valid  in  1  rx.c0.mmioWrValid.
- wr_addr  in  ADDR_W  MMIO header address.
- wr_data  in  DATA_W  rx.c0.data[63:0].
- q_ready  in  1  consumer accepts head entry this cycle.
- clr_ovf  in  1  clears the overflow flag.
- q_valid  out  1  head entry valid.
- q_addr  out  ADDR_W  head entry address.
- q_data  out  DATA_W  head entry data.
- count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow  out  1  sticky; set when a write was dropped.

## Operation
- Push condition: wr_valid && wr_addr == ACCEPT_ADDR. Other addresses are ignored and do not affect count.
- Pop condition: q_valid && q_ready.
- The write pointer and read pointer are each $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked in a separate count register.
- Full with push and no pop: the entry is dropped, overflow is set, and pointers and count are unchanged.
- Full with push and pop in the same cycle: both succeed and count stays at DEPTH.
- Empty with push and pop in the same cycle: the pop is ignored (q_valid=0) and the push is stored.
- Non-full with push and pop in the same cycle: both succeed and count is unchanged.
- Overflow is sticky until clr_ovf. If clr_ovf and a new overflow occur in the same cycle, the set wins.
- Reset: pointers=0, count=0, overflow=0, q_valid=0, full=0, empty=1. Storage contents are not reset. Reset asserted mid-burst discards all entries.

## Timing
- Push at edge N: the entry is visible on q_* after edge N if the FIFO was empty, i.e. 1-cycle latency with fall-through from the registered storage.
- Pop at edge N: the next entry is presented after edge N; there are no bubbles when occupied.
- count, full, empty and overflow are registered and update on the same edge as the push or pop.
- q_addr and q_data are don't-care when q_valid=0.
- There is no combinational path from q_ready to q_valid, q_addr or q_data.

## Structure
- mmio_pkg holds:
  - typedef t_mmio_wr {addr, data};
  - localparam MMIO_USER_REG = 16'h0020;
  - the DFH address constants (0x0000, 0x0002, 0x0004, 0x0006, 0x0008).
- Sub-module mmio_wr_buffer_mem holds the storage array:
  - DEPTH x t_mmio_wr, one write port and one asynchronous read port;
  - it has no reset.
- The top level holds pointers, count, flag logic and address compare.

## Test plan
- Reset, then 3 writes to 0x0020 (data 0xA, 0xB, 0xC) with q_ready=0 -> count=3, q_data=0xA; then q_ready=1 for 3 cycles -> data 0xA, 0xB, 0xC in order, empty=1.
- Write to 0x0024 with data 0xDEAD -> no push, count=0, q_valid stays 0.
- 9 writes to 0x0020 with q_ready=0 -> full=1 after the 8th write, overflow=1 after the 9th, 9th entry absent; clr_ovf pulse -> overflow=0.
- Fill to DEPTH, then push 0x99 and pop in the same cycle -> count stays 8, and 0x99 emerges last after 8 pops.
- Empty FIFO, push 0x5 with q_ready=1 -> entry retained, q_valid=1 the next cycle, count=1.
- Assert rst with 4 entries held -> count=0, empty=1, q_valid=0 immediately (asynchronous); the first push after release is read back correctly.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared MMIO definitions: captured write payload, user register address and DFH map.
package mmio_pkg;

  localparam int unsigned MMIO_ADDR_W = 16;
  localparam int unsigned MMIO_DATA_W = 64;

  localparam logic [MMIO_ADDR_W-1:0] MMIO_USER_REG = 16'h0020;

  // Device feature header register map (32-bit-word addresses)
  localparam logic [MMIO_ADDR_W-1:0] MMIO_DFH_ADDR      = 16'h0000;
  localparam logic [MMIO_ADDR_W-1:0] MMIO_AFU_ID_L_ADDR = 16'h0002;
  localparam logic [MMIO_ADDR_W-1:0] MMIO_AFU_ID_H_ADDR = 16'h0004;
  localparam logic [MMIO_ADDR_W-1:0] MMIO_NEXT_AFU_ADDR = 16'h0006;
  localparam logic [MMIO_ADDR_W-1:0] MMIO_RSVD_ADDR     = 16'h0008;

  typedef struct packed {
    logic [MMIO_ADDR_W-1:0] addr;
    logic [MMIO_DATA_W-1:0] data;
  } t_mmio_wr;

endpackage

// File: rtl/mmio_wr_buffer_mem.sv
// Storage array for the MMIO write FIFO: one synchronous write port, one asynchronous read port.
module mmio_wr_buffer_mem
  import mmio_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  t_mmio_wr                 wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output t_mmio_wr                 rdata_o
);

  t_mmio_wr mem_q [DEPTH];

  // Contents are deliberately not reset; validity is tracked by the owner.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mmio_wr_buffer.sv
// Captures host MMIO writes to one user address into a circular FIFO drained by valid/ready.
module mmio_wr_buffer
  import mmio_pkg::*;
#(
  parameter int unsigned             DEPTH       = 8,
  parameter int unsigned             ADDR_W      = 16,
  parameter int unsigned             DATA_W      = 64,
  parameter logic [ADDR_W-1:0]       ACCEPT_ADDR = ADDR_W'(MMIO_USER_REG)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     q_ready,
  input  logic                     clr_ovf,
  output logic                     q_valid,
  output logic [ADDR_W-1:0]        q_addr,
  output logic [DATA_W-1:0]        q_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             ovf_q, ovf_d;

  logic     push, pop, push_ok, drop;
  t_mmio_wr wr_entry, rd_entry;

  assign push    = wr_valid && (wr_addr == ACCEPT_ADDR);
  assign pop     = !empty_q && q_ready;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign push_ok = push && (!full_q || pop);
  assign drop    = push && full_q && !pop;

  assign wr_entry.addr = MMIO_ADDR_W'(wr_addr);
  assign wr_entry.data = MMIO_DATA_W'(wr_data);

  mmio_wr_buffer_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (push_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A new drop outranks a clear in the same cycle.
    if (clr_ovf) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;

    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
    end
  end

  assign q_valid  = !empty_q;
  assign q_addr   = ADDR_W'(rd_entry.addr);
  assign q_data   = DATA_W'(rd_entry.data);
  assign count    = count_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign overflow = ovf_q;

endmodule
